seq_controller: RTL and testbench

Multi-cycle sequencer for the SEQ Y86-64 processor. Owns the architectural PC and steps each instruction through six one-cycle phases (fetch, decode, execute, memory, writeback, PC update), emitting one-hot stage strobes. Captures fetch-stage results, selects the next PC, and halts with a Y86 status code on halt, invalid instruction or memory error. Sits above the fetch/decode/execute/memory/writeback blocks and drives their PC input and enables.

---
 rtl/seq_controller.sv | 190 +++++++++++++++++++
 tb/tb_seq_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// Multi-cycle SEQ Y86-64 sequencer: owns the PC, steps each instruction through six
// one-hot phases and halts with a Y86 status code. Define SEQ_CTRL_STEP_EN for single-step PAUSE.
module seq_controller #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic             invalid_inst,
    input  logic             imem_error,
    input  logic             halt,
    input  logic             cnd,
    input  logic [63:0]      valM,
    input  logic             dmem_error,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pcu_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCU,
`ifdef SEQ_CTRL_STEP_EN
        S_PAUSE,
`endif
        S_HALTED
    } state_e;

    state_e state_q, state_d;

    logic [63:0]      pc_q, pc_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       icode_q, icode_d;
    logic [63:0]      valc_q, valc_d;
    logic [63:0]      valp_q, valp_d;
    logic [63:0]      valm_q, valm_d;
    logic             cnd_q, cnd_d;

    logic             fetch_fault;
    logic [63:0]      next_pc;

`ifndef SEQ_CTRL_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    assign fetch_fault = imem_error | invalid_inst | halt | (icode == ICODE_HALT);

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset
    // sampled on the clock edge, so every register here comes out of reset together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise unlisted case arms infer latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = fetch_fault ? S_HALTED : S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM:    state_d = dmem_error ? S_HALTED : S_WB;
            S_WB:     state_d = S_PCU;
`ifdef SEQ_CTRL_STEP_EN
            S_PCU:    state_d = S_PAUSE;
            S_PAUSE:  if (step) state_d = S_FETCH;
`else
            S_PCU:    state_d = S_FETCH;
`endif
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_en  = (state_q == S_FETCH);
        decode_en = (state_q == S_DECODE);
        exec_en   = (state_q == S_EXEC);
        mem_en    = (state_q == S_MEM);
        wb_en     = (state_q == S_WB);
        pcu_en    = (state_q == S_PCU);
        done      = (state_q == S_HALTED);
        busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    end

    always_comb begin
        case (icode_q)
            ICODE_CALL: next_pc = valc_q;
            ICODE_JXX:  next_pc = cnd_q ? valc_q : valp_q;
            ICODE_RET:  next_pc = valm_q;
            default:    next_pc = valp_q;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        icode_d = icode_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        valm_d  = valm_q;
        cnd_d   = cnd_q;
        case (state_q)
            S_FETCH: begin
                icode_d = icode;
                valc_d  = valC;
                valp_d  = valP;
                if (imem_error)        stat_d = STAT_ADR;
                else if (invalid_inst) stat_d = STAT_INS;
                else if (fetch_fault)  stat_d = STAT_HLT;
            end
            S_EXEC: cnd_d = cnd;
            S_MEM: begin
                valm_d = valM;
                if (dmem_error) stat_d = STAT_ADR;
            end
            S_PCU: begin
                pc_d  = next_pc;
                cnt_d = cnt_q + CNT_ONE;
            end
            default: ;
        endcase
    end

    // A faulting instruction never reaches PCU, so pc keeps its address and it is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
            icode_q <= '0;
            valc_q  <= '0;
            valp_q  <= '0;
            valm_q  <= '0;
            cnd_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            icode_q <= icode_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            valm_q  <= valm_d;
            cnd_q   <= cnd_d;
        end
    end

    assign pc        = pc_q;
    assign stat      = stat_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed vector table, corner sequences and a
// randomized instruction stream checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n, start, step;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM;
    logic        invalid_inst, imem_error, halt, cnd, dmem_error;
    logic [63:0] pc;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pcu_en;
    logic [2:0]  stat;
    logic        busy, done;
    logic [31:0] instr_cnt;
    logic [5:0]  strobes;

    always #5 clk = ~clk;

    assign strobes = {pcu_en, wb_en, mem_en, exec_en, decode_en, fetch_en};

    seq_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .icode(icode), .valC(valC), .valP(valP),
        .invalid_inst(invalid_inst), .imem_error(imem_error), .halt(halt),
        .cnd(cnd), .valM(valM), .dmem_error(dmem_error),
        .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pcu_en(pcu_en),
        .stat(stat), .busy(busy), .done(done), .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valc, valp, valm;
        logic        cnd, inv, imem, hlt, dmem;
        logic [63:0] exp_pc;
        logic [2:0]  exp_stat;
        logic [31:0] exp_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] vc, vp, vm,
                                input logic c, inv, imem, hlt, dmem,
                                input logic [63:0] epc, input logic [2:0] est,
                                input logic [31:0] ecnt);
        vec_t v;
        v.icode = ic; v.valc = vc; v.valp = vp; v.valm = vm;
        v.cnd = c; v.inv = inv; v.imem = imem; v.hlt = hlt; v.dmem = dmem;
        v.exp_pc = epc; v.exp_stat = est; v.exp_cnt = ecnt;
        return v;
    endfunction

    // Instruction-level reference: fault priority, then next-PC rule and retirement count.
    task automatic predict(inout vec_t v);
        if (v.imem)                         m_stat = 3'd3;
        else if (v.inv)                     m_stat = 3'd4;
        else if (v.hlt || v.icode == 4'h0)  m_stat = 3'd2;
        else if (v.dmem)                    m_stat = 3'd3;
        else begin
            if (v.icode == 4'h8 || (v.icode == 4'h7 && v.cnd)) m_pc = v.valc;
            else if (v.icode == 4'h9)                          m_pc = v.valm;
            else                                               m_pc = v.valp;
            m_cnt = m_cnt + 32'd1;
        end
        v.exp_pc = m_pc; v.exp_stat = m_stat; v.exp_cnt = m_cnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_pc", pc, 64'd0);
        check("rst_stat", stat, 3'd1);
        check("rst_cnt", instr_cnt, 32'd0);
        check("rst_strobes", strobes, 6'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", {strobes, busy}, 7'd0);
        m_pc = 64'd0; m_stat = 3'd1; m_cnt = 32'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        check("start_latency", fetch_en, 1'b1);
        start = 1'b0;
    endtask

    // Drives each phase's inputs only in its own cycle (random elsewhere) and checks the strobe walk.
    task automatic run_instr(input vec_t v);
        int  n, last;
        bit  ffault, dfault;
        ffault = v.imem | v.inv | v.hlt | (v.icode == 4'h0);
        dfault = !ffault && v.dmem;
        last   = ffault ? 0 : (dfault ? 3 : 5);
        n = 0;
        while (fetch_en !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (fetch_en !== 1'b1) begin
            check("fetch_timeout", 64'd0, 64'd1);
            return;
        end
        for (int p = 0; p <= last; p++) begin
            if (p > 0) @(negedge clk);
            check($sformatf("strobe_ph%0d", p), strobes, 64'd1 << p);
            icode        = (p == 0) ? v.icode : 4'($urandom);
            valC         = (p == 0) ? v.valc  : {$urandom, $urandom};
            valP         = (p == 0) ? v.valp  : {$urandom, $urandom};
            invalid_inst = (p == 0) ? v.inv   : 1'($urandom);
            imem_error   = (p == 0) ? v.imem  : 1'($urandom);
            halt         = (p == 0) ? v.hlt   : 1'($urandom);
            cnd          = (p == 2) ? v.cnd   : 1'($urandom);
            valM         = (p == 3) ? v.valm  : {$urandom, $urandom};
            dmem_error   = (p == 3) ? v.dmem  : 1'($urandom);
        end
        @(negedge clk);
        if (last == 5) begin
`ifdef SEQ_CTRL_STEP_EN
            for (int k = 0; k < 3; k++) begin
                check("pause_busy", busy, 1'b1);
                check("pause_strobes", strobes, 6'd0);
                @(negedge clk);
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
`endif
            check("next_fetch", fetch_en, 1'b1);
            check("done_low", done, 1'b0);
        end else begin
            check("done_high", done, 1'b1);
            check("halt_busy", busy, 1'b0);
            check("halt_strobes", strobes, 6'd0);
        end
        check("pc", pc, v.exp_pc);
        check("stat", stat, v.exp_stat);
        check("instr_cnt", instr_cnt, v.exp_cnt);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        rst_n = 1'b0; start = 1'b0; step = 1'b0;
        icode = '0; valC = '0; valP = '0; valM = '0;
        invalid_inst = 1'b0; imem_error = 1'b0; halt = 1'b0; cnd = 1'b0; dmem_error = 1'b0;

        tbl[0] = mk(4'h3, 64'h77,  64'd10,  64'h5,   1'b0, 0, 0, 0, 0, 64'd10,  3'd1, 32'd1);
        tbl[1] = mk(4'h7, 64'h40,  64'h09,  64'h0,   1'b1, 0, 0, 0, 0, 64'h40,  3'd1, 32'd2);
        tbl[2] = mk(4'h7, 64'h40,  64'h09,  64'h0,   1'b0, 0, 0, 0, 0, 64'h09,  3'd1, 32'd3);
        tbl[3] = mk(4'h8, 64'h80,  64'h12,  64'h0,   1'b1, 0, 0, 0, 0, 64'h80,  3'd1, 32'd4);
        tbl[4] = mk(4'h9, 64'h33,  64'h81,  64'h100, 1'b1, 0, 0, 0, 0, 64'h100, 3'd1, 32'd5);
        tbl[5] = mk(4'h6, 64'h0,   64'h20,  64'h0,   1'b0, 0, 0, 0, 0, 64'h20,  3'd1, 32'd6);
        tbl[6] = mk(4'h0, 64'h0,   64'h21,  64'h0,   1'b0, 0, 0, 1, 0, 64'h20,  3'd2, 32'd6);

        do_reset();
        do_start();
        for (int i = 0; i < 7; i++) run_instr(tbl[i]);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halted_start_strobes", strobes, 6'd0);
            check("halted_done", done, 1'b1);
            check("halted_pc", pc, 64'h20);
        end
        start = 1'b0;

        // imem_error outranks invalid_inst.
        do_reset();
        do_start();
        run_instr(mk(4'h3, 64'h0, 64'h10, 64'h0, 1'b0, 1, 1, 0, 0, 64'd0, 3'd3, 32'd0));

        // Data memory fault: no WB/PCU, pc stays at the faulting instruction.
        do_reset();
        do_start();
        run_instr(mk(4'h3, 64'h0, 64'h30, 64'h0, 1'b0, 0, 0, 0, 0, 64'h30, 3'd1, 32'd1));
        run_instr(mk(4'h5, 64'h0, 64'h99, 64'h0, 1'b0, 0, 0, 0, 1, 64'h30, 3'd3, 32'd1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dmem_no_wb_pcu", {wb_en, pcu_en}, 2'b00);
        end

        // Reset in the middle of an instruction.
        do_reset();
        do_start();
        run_instr(mk(4'h3, 64'h0, 64'd10, 64'h0, 1'b0, 0, 0, 0, 0, 64'd10, 3'd1, 32'd1));
        icode = 4'h3; valP = 64'h50; halt = 1'b0; imem_error = 1'b0; invalid_inst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_exec", exec_en, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pc", pc, 64'd0);
        check("midrst_stat", stat, 3'd1);
        check("midrst_cnt", instr_cnt, 32'd0);
        check("midrst_strobes", strobes, 6'd0);
        check("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {strobes, busy, done}, 8'd0);

        // Random instruction stream against the reference model.
        do_reset();
        do_start();
        for (int i = 0; i < 150; i++) begin
            v.icode = ($urandom_range(0, 29) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
            v.valc  = {$urandom, $urandom};
            v.valp  = {$urandom, $urandom};
            v.valm  = {$urandom, $urandom};
            v.cnd   = 1'($urandom);
            v.inv   = ($urandom_range(0, 39) == 0);
            v.imem  = ($urandom_range(0, 39) == 0);
            v.hlt   = ($urandom_range(0, 39) == 0);
            v.dmem  = ($urandom_range(0, 39) == 0);
            predict(v);
            run_instr(v);
            if (m_stat != 3'd1) begin
                do_reset();
                do_start();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
